// File: rtl/grasspopper_apb_master.sv
// APB requester for the grasspopper cipher peripheral: turns one valid/ready
// command into one SETUP/ACCESS transfer and returns data/status on a response port.
module grasspopper_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [2:0]          PPROT,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                started_q;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [2:0]          pprot_q, pprot_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  // started_q keeps cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      started_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pprot_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pprot_q   <= pprot_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pprot_d  = pprot_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pprot_d  = cmd_prot;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion is checked first so a late PREADY beats the timeout.
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = started_q && (state_q == IDLE);
  assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PPROT       = pprot_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_grasspopper_apb_master.sv
// Self-checking bench for grasspopper_apb_master: directed scenarios plus
// randomized transfers compared against a transaction-level expectation.
module tb_grasspopper_apb_master;

  localparam int TO = 4;

  logic         PCLK;
  logic         PRESETN;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic [15:0]  cmd_strb;
  logic [2:0]   cmd_prot;
  logic         rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [127:0] rsp_rdata;
  logic [31:0]  PADDR;
  logic [2:0]   PPROT;
  logic         PSEL, PENABLE, PWRITE;
  logic [127:0] PWDATA;
  logic [15:0]  PSTRB;
  logic         PREADY, PSLVERR;
  logic [127:0] PRDATA;

  int checks = 0;
  int passed = 0;

  grasspopper_apb_master #(.ADDR_W(32), .DATA_W(128), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Observations recorded by the transfer driver
  int           obs_setup, obs_access, obs_lat;
  logic         obs_changed, obs_busy_ready, obs_psel_resp, obs_unstable;
  logic         obs_ready_after, obs_valid_after, obs_ready_idle;
  logic [127:0] obs_rdata;
  logic         obs_err, obs_to;
  logic [31:0]  snap_paddr;
  logic         snap_pwrite;
  logic [2:0]   snap_pprot;
  logic [127:0] snap_pwdata;
  logic [15:0]  snap_pstrb;

  // Expectations from the transaction-level model
  int           exp_access, exp_lat;
  logic [127:0] exp_rdata, exp_pwdata;
  logic [15:0]  exp_pstrb;
  logic         exp_err, exp_to;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // A transfer whose slave needs 'waits' stall cycles times out once the
  // stall reaches the TO-cycle ACCESS budget; otherwise it runs waits+1 ACCESS cycles.
  task automatic predict(input logic wr, input logic [127:0] wd, input logic [15:0] sb,
                         input int waits, input logic [127:0] rd, input logic serr);
    exp_to     = (waits >= TO);
    exp_access = exp_to ? TO : waits + 1;
    exp_lat    = exp_access + 2;
    exp_rdata  = (wr || exp_to) ? 128'h0 : rd;
    exp_err    = exp_to || serr;
    exp_pwdata = wr ? wd : 128'h0;
    exp_pstrb  = wr ? sb : 16'h0;
  endtask

  // Drives one command from a negedge with cmd_ready expected high, plays the
  // slave, applies bp cycles of response backpressure and records what it saw.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                               input logic [15:0] sb, input logic [2:0] pr, input int waits,
                               input logic [127:0] rd, input logic serr, input int bp,
                               input logic keep_valid);
    int k;
    logic done;
    obs_ready_idle = cmd_ready;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = sb; cmd_prot = pr;
    rsp_ready = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = keep_valid;
    cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = rand128();
    cmd_strb = 16'($urandom); cmd_prot = 3'($urandom);
    obs_setup = 0; obs_access = 0; obs_lat = -1; obs_changed = 1'b0; obs_busy_ready = 1'b0;
    obs_psel_resp = 1'b0; obs_unstable = 1'b0;
    k = 1; done = 1'b0;
    while (!done && k <= 40) begin
      if (cmd_ready) obs_busy_ready = 1'b1;
      if (PSEL && !PENABLE) begin
        obs_setup++;
        if (obs_setup == 1) begin
          snap_paddr = PADDR; snap_pwrite = PWRITE; snap_pprot = PPROT;
          snap_pwdata = PWDATA; snap_pstrb = PSTRB;
        end
      end
      if (obs_setup > 0 && (PADDR !== snap_paddr || PWRITE !== snap_pwrite || PPROT !== snap_pprot ||
                            PWDATA !== snap_pwdata || PSTRB !== snap_pstrb))
        obs_changed = 1'b1;
      if (PSEL && PENABLE) begin
        if (obs_access == waits) begin
          PREADY = 1'b1; PRDATA = rd; PSLVERR = serr;
        end else begin
          PREADY = 1'b0; PRDATA = rand128(); PSLVERR = 1'($urandom_range(0, 1));
        end
        obs_access++;
      end else begin
        PREADY = 1'b0;
      end
      if (rsp_valid) begin
        obs_lat = k; done = 1'b1;
      end else begin
        @(negedge PCLK);
        k++;
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
    obs_psel_resp = PSEL || PENABLE;
    for (int i = 0; i < bp; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err ||
          rsp_timeout !== obs_to || PSEL !== 1'b0 || cmd_ready !== 1'b0)
        obs_unstable = 1'b1;
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    obs_ready_after = cmd_ready;
    obs_valid_after = rsp_valid;
    if (PADDR !== snap_paddr || PWDATA !== snap_pwdata || PSTRB !== snap_pstrb) obs_changed = 1'b1;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, rsp_err, rsp_timeout} !== 7'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, rsp_err, rsp_timeout});
    else passed++;
    checks++;
    if ({PADDR, PPROT, PSTRB} !== 51'h0 || PWDATA !== 128'h0 || rsp_rdata !== 128'h0)
      $display("[TB] FAIL reset_data: got paddr=%0h pwdata=%0h rdata=%0h expected 0", PADDR, PWDATA, rsp_rdata);
    else passed++;
    @(negedge PCLK);
    PRESETN = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) $display("[TB] FAIL reset_ready_early: got %b expected 0", cmd_ready);
    else passed++;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready_first_edge: got %b expected 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_zero_wait_write();
    applyStimulus(1'b1, 32'h10, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, 3'd2,
                  0, 128'h0, 1'b0, 0, 1'b0);
    checks++;
    if (obs_ready_idle !== 1'b1) $display("[TB] FAIL zw_cmd_ready: got %b expected 1", obs_ready_idle);
    else passed++;
    checks++;
    if (obs_setup !== 1 || obs_access !== 1)
      $display("[TB] FAIL zw_phases: got setup=%0d access=%0d expected 1/1", obs_setup, obs_access);
    else passed++;
    checks++;
    if (obs_lat !== 3) $display("[TB] FAIL zw_latency: got %0d expected 3", obs_lat);
    else passed++;
    checks++;
    if (obs_err !== 1'b0 || obs_to !== 1'b0 || obs_rdata !== 128'h0)
      $display("[TB] FAIL zw_rsp: got err=%b to=%b rdata=%0h expected 0/0/0", obs_err, obs_to, obs_rdata);
    else passed++;
    checks++;
    if (snap_paddr !== 32'h10 || snap_pwrite !== 1'b1 || snap_pprot !== 3'd2 ||
        snap_pwdata !== 128'h00112233445566778899AABBCCDDEEFF || snap_pstrb !== 16'hFFFF)
      $display("[TB] FAIL zw_bus: got addr=%0h wr=%b prot=%0d data=%0h strb=%0h", snap_paddr,
               snap_pwrite, snap_pprot, snap_pwdata, snap_pstrb);
    else passed++;
    checks++;
    if (obs_changed !== 1'b0) $display("[TB] FAIL zw_bus_hold: got changed=%b expected 0", obs_changed);
    else passed++;
  endtask

  task automatic test_wait_read();
    applyStimulus(1'b0, 32'h24, rand128(), 16'hFFFF, 3'd0, 3,
                  128'h7F679D90BEBC24305A468D42B9D4EDCD, 1'b0, 0, 1'b0);
    checks++;
    if (obs_rdata !== 128'h7F679D90BEBC24305A468D42B9D4EDCD)
      $display("[TB] FAIL wr3_rdata: got %0h expected 7f679d90bebc24305a468d42b9d4edcd", obs_rdata);
    else passed++;
    checks++;
    if (obs_lat !== 6 || obs_access !== 4)
      $display("[TB] FAIL wr3_latency: got lat=%0d access=%0d expected 6/4", obs_lat, obs_access);
    else passed++;
    checks++;
    if (snap_paddr !== 32'h24 || obs_changed !== 1'b0)
      $display("[TB] FAIL wr3_paddr: got addr=%0h changed=%b expected 24/0", snap_paddr, obs_changed);
    else passed++;
    checks++;
    if (snap_pstrb !== 16'h0 || snap_pwdata !== 128'h0 || snap_pwrite !== 1'b0)
      $display("[TB] FAIL wr3_read_zero: got strb=%0h data=%0h wr=%b expected 0", snap_pstrb, snap_pwdata, snap_pwrite);
    else passed++;
  endtask

  task automatic test_slave_error();
    applyStimulus(1'b0, 32'h30, 128'h0, 16'h0, 3'd1, 0, 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0,
                  1'b1, 0, 1'b0);
    checks++;
    if (obs_err !== 1'b1 || obs_to !== 1'b0)
      $display("[TB] FAIL slverr_flags: got err=%b to=%b expected 1/0", obs_err, obs_to);
    else passed++;
    checks++;
    if (obs_rdata !== 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0)
      $display("[TB] FAIL slverr_rdata: got %0h expected deadbeef0badf00d123456789abcdef0", obs_rdata);
    else passed++;
  endtask

  task automatic test_timeout();
    applyStimulus(1'b0, 32'h40, 128'h0, 16'h0, 3'd0, 100, rand128(), 1'b0, 0, 1'b0);
    checks++;
    if (obs_access !== TO || obs_lat !== TO + 2)
      $display("[TB] FAIL to_length: got access=%0d lat=%0d expected %0d/%0d", obs_access, obs_lat, TO, TO + 2);
    else passed++;
    checks++;
    if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== 128'h0)
      $display("[TB] FAIL to_rsp: got err=%b to=%b rdata=%0h expected 1/1/0", obs_err, obs_to, obs_rdata);
    else passed++;
    checks++;
    if (obs_psel_resp !== 1'b0) $display("[TB] FAIL to_psel_drop: got %b expected 0", obs_psel_resp);
    else passed++;
    applyStimulus(1'b0, 32'h44, 128'h0, 16'h0, 3'd0, TO - 1, 128'hCAFE, 1'b0, 0, 1'b0);
    checks++;
    if (obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 128'hCAFE || obs_access !== TO)
      $display("[TB] FAIL to_late_ready: got to=%b err=%b rdata=%0h access=%0d expected 0/0/cafe/%0d",
               obs_to, obs_err, obs_rdata, obs_access, TO);
    else passed++;
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b0, 32'h50, 128'h0, 16'h0, 3'd3, 1, 128'h5A5A_A5A5, 1'b0, 5, 1'b1);
    checks++;
    if (obs_unstable !== 1'b0) $display("[TB] FAIL bp_hold: got unstable=%b expected 0", obs_unstable);
    else passed++;
    checks++;
    if (obs_busy_ready !== 1'b0) $display("[TB] FAIL bp_cmd_ready_busy: got %b expected 0", obs_busy_ready);
    else passed++;
    checks++;
    if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0)
      $display("[TB] FAIL bp_after_handshake: got ready=%b valid=%b expected 1/0", obs_ready_after, obs_valid_after);
    else passed++;
    checks++;
    if (obs_changed !== 1'b0 || snap_paddr !== 32'h50 || obs_rdata !== 128'h5A5A_A5A5)
      $display("[TB] FAIL bp_no_requeue: got changed=%b addr=%0h rdata=%0h expected 0/50/5a5aa5a5",
               obs_changed, snap_paddr, obs_rdata);
    else passed++;
  endtask

  task automatic test_random();
    logic         wr, serr;
    logic [31:0]  addr;
    logic [127:0] wd, rd;
    logic [15:0]  sb;
    logic [2:0]   pr;
    int           waits, bp;
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1)); serr = 1'($urandom_range(0, 1));
      addr = $urandom; wd = rand128(); rd = rand128(); sb = 16'($urandom); pr = 3'($urandom);
      waits = $urandom_range(0, 6); bp = $urandom_range(0, 3);
      predict(wr, wd, sb, waits, rd, serr);
      applyStimulus(wr, addr, wd, sb, pr, waits, rd, serr, bp, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_lat !== exp_lat || obs_access !== exp_access || obs_setup !== 1)
        $display("[TB] FAIL rnd%0d_timing: got lat=%0d access=%0d setup=%0d expected %0d/%0d/1",
                 n, obs_lat, obs_access, obs_setup, exp_lat, exp_access);
      else passed++;
      checks++;
      if (obs_rdata !== exp_rdata || obs_err !== exp_err || obs_to !== exp_to)
        $display("[TB] FAIL rnd%0d_rsp: got rdata=%0h err=%b to=%b expected %0h/%b/%b",
                 n, obs_rdata, obs_err, obs_to, exp_rdata, exp_err, exp_to);
      else passed++;
      checks++;
      if (snap_paddr !== addr || snap_pwrite !== wr || snap_pprot !== pr ||
          snap_pwdata !== exp_pwdata || snap_pstrb !== exp_pstrb || obs_changed !== 1'b0)
        $display("[TB] FAIL rnd%0d_bus: got addr=%0h wr=%b prot=%0d data=%0h strb=%0h changed=%b",
                 n, snap_paddr, snap_pwrite, snap_pprot, snap_pwdata, snap_pstrb, obs_changed);
      else passed++;
      checks++;
      if (obs_unstable !== 1'b0 || obs_busy_ready !== 1'b0 || obs_ready_after !== 1'b1)
        $display("[TB] FAIL rnd%0d_flow: got unstable=%b busy_ready=%b ready_after=%b expected 0/0/1",
                 n, obs_unstable, obs_busy_ready, obs_ready_after);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_access();
    logic stale;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; cmd_prot = 3'd0;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) $display("[TB] FAIL rst_mid_in_access: got %b expected 11", {PSEL, PENABLE});
    else passed++;
    #2;
    PRESETN = 1'b0;
    PREADY = 1'b1; PRDATA = rand128();
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0)
      $display("[TB] FAIL rst_mid_async: got %b expected 0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
    else passed++;
    @(negedge PCLK);
    PRESETN = 1'b1;
    PREADY = 1'b0;
    @(posedge PCLK);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("[TB] FAIL rst_mid_release: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
    else passed++;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) $display("[TB] FAIL rst_mid_stale_rsp: got %b expected 0", stale);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
